ieee_decoder: RTL and testbench
===============================

IEEE_DECODER -- requirements
Module: ieee_decoder

Interface
REQ-001 Parameter: FP_W, 36, fixed-point output width.
REQ-002 Parameter: FRAC_W, 24, fraction bits in output (bit FRAC_W weighs 1.0).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  request; sampled only in IDLE.
REQ-006 Port: sp_ieee  input  32  single-precision word {sign, exp[7:0], mant[22:0]}.
REQ-007 Port: fp  output  FP_W  unsigned fixed-point result, registered.
REQ-008 Port: done  output  1  high exactly while in DONE (one cycle).
REQ-009 Port: ovf  output  1  result saturated; valid with done, held until next capture.
REQ-010 Port: unf  output  1  nonzero input flushed to 0; same timing as ovf.
REQ-011 Port: state  output  2  FSM state: 0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE.

Function
REQ-012 The block SHALL decode magnitude only; the sign bit SHALL be ignored.
REQ-013 In IDLE with enable=1, the block SHALL capture sp_ieee and go to LOAD; with enable=0 it SHALL stay in IDLE.
REQ-014 enable outside IDLE SHALL be ignored; inputs are not re-sampled until the FSM is back in IDLE.
REQ-015 In LOAD, with e=exp and p=e-103 (leading-one bit position), classification SHALL be:
- e=0: fp<=0, flags 0, go DONE.
- e=255 or e>138: fp<=all ones, ovf<=1, go DONE.
- 1<=e<=102: fp<=0, unf<=1, go DONE.
- 103<=e<=138: work<={1'b1, mant, 12'b0}, counter<=35-p, go SHIFT.
REQ-016 In SHIFT with counter!=0, each cycle SHALL do work<=work>>1 and counter<=counter-1.
REQ-017 In SHIFT with counter==0, fp<=work and done<=1, go DONE.
REQ-018 DONE SHALL last one cycle, then go IDLE with done<=0.
REQ-019 Mantissa bits shifted below bit 0 SHALL be truncated, with no rounding.
REQ-020 Latency (edge sampling enable to done high) SHALL be N+3 cycles with N=35-p, so 3..38 cycles; special cases SHALL take 2 cycles.
REQ-021 fp, ovf and unf SHALL change only on entry to DONE and hold until the next DONE.
REQ-022 A new request SHALL be accepted no earlier than the cycle after DONE; back-to-back throughput is one result per N+4 cycles.
REQ-023 e=103 SHALL produce fp=1 (LSB), and e=138 SHALL produce a leading one at bit 35.

Reset
REQ-024 While rst=1 at a clock edge: state<=IDLE, fp<=0, done<=0, ovf<=0, unf<=0, counter<=0, work<=0.
REQ-025 rst SHALL override enable in the same cycle, and the request SHALL be dropped.
REQ-026 rst in any state mid-operation SHALL abort the operation with no done pulse.

Structure
REQ-027 Package ieee_pkg SHALL hold:
- state encoding (IDLE, LOAD, SHIFT, DONE);
- IEEE_BIAS=127, EXP_OFFSET=103, EXP_MAX=138, FP_W, FRAC_W.
- The encoder shares this package.
REQ-028 The block SHALL be a single module with no sub-module and all outputs registered.

Verification
REQ-029 rst held 2 cycles, then released -> state=0, fp=0, done=0, ovf=0, unf=0.
REQ-030 sp_ieee=0x3F800000 (1.0) -> fp=0x001000000 and done high 14 cycles after the enable edge; sp_ieee=0x3FC00000 -> fp=0x001800000.
REQ-031 sp_ieee=0x45000000 (2048.0) -> fp=0x800000000 with 3-cycle latency; sp_ieee=0x33800000 -> fp=0x000000001.
REQ-032 Special inputs:
- 0x7F800000 -> fp=0xFFFFFFFFF, ovf=1;
- 0x33000000 -> fp=0, unf=1;
- 0x00000000 -> fp=0, no flags;
- all three at 2-cycle latency.
REQ-033 0xBF800000 -> identical to 0x3F800000; enable pulsed during SHIFT with another value -> no effect on the result.
REQ-034 rst asserted in the 5th SHIFT cycle of a 1.0 decode -> next cycle state=0, fp=0, no done; a fresh request afterwards completes correctly.

Source files
------------

// File: rtl/ieee_pkg.sv
// ieee_pkg: shared constants and FSM encoding for the IEEE-754 single
// precision <-> unsigned fixed-point decoder/encoder pair.
//   state_t    : IDLE/LOAD/SHIFT/DONE encoding (also driven on the state port)
//   IEEE_BIAS  : single-precision exponent bias
//   EXP_OFFSET : exponent whose leading one lands on fixed-point bit 0
//   EXP_MAX    : exponent whose leading one lands on the top fixed-point bit
//   FP_W/FRAC_W: fixed-point width and fraction bits
package ieee_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int IEEE_BIAS  = 127;
  localparam int EXP_OFFSET = 103;
  localparam int EXP_MAX    = 138;
  localparam int FP_W       = 36;
  localparam int FRAC_W     = 24;
  localparam int MANT_W     = 23;

endpackage

// File: rtl/ieee_decoder.sv
// ieee_decoder: converts the magnitude of an IEEE-754 single-precision word
// into an unsigned fixed-point value with FRAC_W fraction bits, using a
// serial right-shifter (one bit per cycle).
//   clk, rst : clock, synchronous active-high reset
//   enable   : request, only looked at in IDLE
//   sp_ieee  : {sign, exp[7:0], mant[22:0]}; sign is ignored
//   fp       : registered fixed-point result, held between results
//   done     : one-cycle pulse while in DONE
//   ovf/unf  : saturated / flushed-to-zero flags, updated with fp
//   state    : current FSM state
module ieee_decoder #(
  parameter int FP_W   = 36,
  parameter int FRAC_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [31:0]     sp_ieee,
  output logic [FP_W-1:0] fp,
  output logic            done,
  output logic            ovf,
  output logic            unf,
  output logic [1:0]      state
);
  import ieee_pkg::*;

  // Leading one of the mantissa sits at work[FP_W-1] right after LOAD.
  localparam int PAD_W = FP_W - 1 - MANT_W;
  // Exponent window whose leading one lands inside the fp word.
  localparam logic [7:0] EXP_LO = 8'(IEEE_BIAS - FRAC_W);
  localparam logic [7:0] EXP_HI = 8'(IEEE_BIAS - FRAC_W + FP_W - 1);

  state_t            state_q, state_d;
  logic [30:0]       mag_q, mag_d;
  logic [FP_W-1:0]   work_q, work_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [FP_W-1:0]   fp_q, fp_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [7:0]        exp_w;

  // Magnitude only: the sign bit is never captured.
  logic sign_unused;
  assign sign_unused = sp_ieee[31];

  assign exp_w = mag_q[30:23];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (enable) begin
          mag_d   = sp_ieee[30:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (exp_w == 8'd0) begin
          // Zero and denormals both decode to 0 without a flag.
          fp_d    = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (exp_w == 8'd255 || exp_w > EXP_HI) begin
          fp_d    = '1;
          ovf_d   = 1'b1;
          unf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (exp_w < EXP_LO) begin
          fp_d    = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          work_d  = {1'b1, mag_q[22:0], {PAD_W{1'b0}}};
          // Shift count = distance of the leading one from the top bit.
          cnt_d   = 6'(EXP_HI - exp_w);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != 6'd0) begin
          work_d = work_q >> 1;  // bits falling off the bottom are truncated
          cnt_d  = cnt_q - 6'd1;
        end else begin
          fp_d    = work_q;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      fp_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign fp    = fp_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign state = state_q;

endmodule

// File: tb/tb_ieee_decoder.sv
module tb_ieee_decoder;

  localparam int FP_W = 36;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [31:0]     sp_ieee;
  logic [FP_W-1:0] fp;
  logic            done;
  logic            ovf;
  logic            unf;
  logic [1:0]      state;

  int compared   = 0;
  int mismatched = 0;

  ieee_decoder #(.FP_W(36), .FRAC_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sp_ieee(sp_ieee),
    .fp(fp), .done(done), .ovf(ovf), .unf(unf), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: value = 1.m * 2^(e-127), scaled by 2^24 and floored.
  // Latency counts clock edges from the capture edge to the edge raising done.
  function automatic void model(input logic [31:0] w, output logic [FP_W-1:0] f,
                                output logic o, output logic u, output int lat);
    int e;
    logic [63:0] sig;
    e   = int'(w[30:23]);
    sig = 64'h80_0000 | 64'(w[22:0]);
    o = 1'b0; u = 1'b0; f = '0; lat = 2;
    if (e == 0) begin
      f = '0;
    end else if (e == 255 || e > 138) begin
      f = '1; o = 1'b1;
    end else if (e < 103) begin
      u = 1'b1;
    end else begin
      if (e >= 126) f = FP_W'(sig << (e - 126));
      else          f = FP_W'(sig >> (126 - e));
      lat = (35 - (e - 103)) + 3;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check result, flags, latency and result hold.
  // glitch: pulse enable with a different word while the FSM is busy.
  task automatic decode(input logic [31:0] w, input bit glitch, input string tag);
    logic [FP_W-1:0] ef, prev_fp;
    logic eo, eu;
    int elat, k;
    bit seen;
    model(w, ef, eo, eu, elat);
    prev_fp = fp;
    enable  = 1'b1;
    sp_ieee = w;
    @(posedge clk); #1;
    enable  = 1'b0;
    sp_ieee = $urandom;
    k = 1;
    seen = 1'b0;
    chk({tag, " state_load"}, 64'(state), 64'd1);
    while (k < 60) begin
      if (glitch && k == 4) begin
        enable  = 1'b1;
        sp_ieee = 32'h4400_0000 | 32'($urandom_range(0, 32'h7F_FFFF));
      end else begin
        enable  = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk({tag, " fp_hold"}, 64'(fp), 64'(prev_fp));
    end
    enable = 1'b0;
    if (!seen) begin
      compared++;
      mismatched++;
      $error("FAIL %s timeout: observed=no done expected=done within 60", tag);
    end else begin
      chk({tag, " fp"}, 64'(fp), 64'(ef));
      chk({tag, " ovf"}, 64'(ovf), 64'(eo));
      chk({tag, " unf"}, 64'(unf), 64'(eu));
      chk({tag, " latency"}, 64'(k), 64'(elat));
      chk({tag, " state_done"}, 64'(state), 64'd3);
      @(posedge clk); #1;
      chk({tag, " done_drop"}, 64'(done), 64'd0);
      chk({tag, " state_idle"}, 64'(state), 64'd0);
      chk({tag, " fp_keep"}, 64'(fp), 64'(ef));
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  e;
    logic        s;
    int          sel;

    rst = 1'b1; enable = 1'b0; sp_ieee = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst state", 64'(state), 64'd0);
    chk("rst fp",    64'(fp),    64'd0);
    chk("rst done",  64'(done),  64'd0);
    chk("rst ovf",   64'(ovf),   64'd0);
    chk("rst unf",   64'(unf),   64'd0);

    // Idle with enable low must stay idle.
    repeat (3) @(posedge clk);
    #1 chk("idle hold", 64'(state), 64'd0);

    decode(32'h3F80_0000, 1'b0, "one");
    chk("one exact", 64'(fp), 64'h0_0100_0000);
    decode(32'h3FC0_0000, 1'b0, "one_half");
    chk("one_half exact", 64'(fp), 64'h0_0180_0000);
    decode(32'h4500_0000, 1'b0, "e138");
    chk("e138 exact", 64'(fp), 64'h8_0000_0000);
    decode(32'h3380_0000, 1'b0, "e103");
    chk("e103 exact", 64'(fp), 64'h0_0000_0001);
    decode(32'h7F80_0000, 1'b0, "inf");
    chk("inf exact", 64'(fp), 64'hF_FFFF_FFFF);
    decode(32'h3300_0000, 1'b0, "e102");
    chk("e102 unf", 64'(unf), 64'd1);
    decode(32'h0000_0000, 1'b0, "zero");
    decode(32'hBF80_0000, 1'b0, "neg_one");
    chk("neg_one exact", 64'(fp), 64'h0_0100_0000);
    decode(32'h3F80_0000, 1'b1, "glitch");
    decode(32'h4A00_0000, 1'b0, "big");
    decode(32'h3FFF_FFFF, 1'b0, "trunc");

    // Reset in the 5th SHIFT cycle of a 1.0 decode.
    enable = 1'b1; sp_ieee = 32'h3F80_0000;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("abort in_shift", 64'(state), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort state", 64'(state), 64'd0);
    chk("abort fp",    64'(fp),    64'd0);
    chk("abort done",  64'(done),  64'd0);
    begin
      bit any_done = 1'b0;
      repeat (15) begin
        @(posedge clk); #1;
        if (done) any_done = 1'b1;
      end
      chk("abort no_done", 64'(any_done), 64'd0);
    end
    decode(32'h3F80_0000, 1'b0, "after_abort");

    // Reset overrides a same-cycle request.
    rst = 1'b1; enable = 1'b1; sp_ieee = 32'h3F80_0000;
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_en state", 64'(state), 64'd0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: e = 8'd0;
        1: e = 8'd255;
        2: e = 8'($urandom_range(139, 254));
        3: e = 8'($urandom_range(1, 102));
        default: e = 8'($urandom_range(103, 138));
      endcase
      s = 1'($urandom_range(0, 1));
      w = {s, e, 23'($urandom)};
      decode(w, (i % 5) == 2, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
